// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states and transaction owners.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Winner select between fetch (I) and load/store (D) requesters.
// ARB_RR_EN defined: round-robin on conflict, otherwise fixed D-over-I priority.
module arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
`ifdef ARB_RR_EN
    input  owner_t last_owner,
`endif
    output logic   any_req,
    output owner_t winner
);

    // A lone requester always wins; only a conflict consults the policy.
    always_comb begin
        any_req = i_req | d_req;
        winner  = OWN_I;
        if (i_req && d_req) begin
`ifdef ARB_RR_EN
            winner = (last_owner == OWN_D) ? OWN_I : OWN_D;
`else
            winner = OWN_D;
`endif
        end else if (d_req) begin
            winner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D).
// One outstanding transaction, registered grant, valid/ready memory handshake.
// Optional macro ARB_RR_EN selects round-robin arbitration (default: D beats I).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_be,
    input  logic            m_ready,
    input  logic            m_rvalid,
    input  logic [DW-1:0]   m_rdata,
    output logic            busy
);

    state_t state_q, state_d;
    owner_t owner_q;
    owner_t winner;
    logic   any_req;
    logic   take;     // latch winner this cycle
    logic   deliver;  // read data returns this cycle

`ifdef ARB_RR_EN
    owner_t last_owner_q;
`endif

    arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
`ifdef ARB_RR_EN
        .last_owner (last_owner_q),
`endif
        .any_req    (any_req),
        .winner     (winner)
    );

    assign m_req = (state_q == ISSUE);
    assign busy  = (state_q != IDLE);

    // State register; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic plus the take/deliver strobes that steer the datapath.
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        deliver = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    take    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // m_rvalid without m_ready is a stray pulse and is ignored.
                if (m_ready) begin
                    if (m_we) begin
                        state_d = IDLE;
                    end else if (m_rvalid) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (m_rvalid) begin
                    deliver = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant/response pulses, latched request copy and per-owner read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q  <= OWN_I;
            i_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_be     <= '0;
        end else begin
            i_gnt    <= take && (winner == OWN_I);
            d_gnt    <= take && (winner == OWN_D);
            i_rvalid <= deliver && (owner_q == OWN_I);
            d_rvalid <= deliver && (owner_q == OWN_D);
            if (take) begin
                owner_q <= winner;
                if (winner == OWN_D) begin
                    m_we    <= d_we;
                    m_addr  <= d_addr;
                    m_wdata <= d_wdata;
                    m_be    <= d_be;
                end else begin
                    // Fetches are always full-word reads.
                    m_we    <= 1'b0;
                    m_addr  <= i_addr;
                    m_wdata <= '0;
                    m_be    <= '0;
                end
            end
            if (deliver && (owner_q == OWN_I)) i_rdata <= m_rdata;
            if (deliver && (owner_q == OWN_D)) d_rdata <= m_rdata;
        end
    end

`ifdef ARB_RR_EN
    // Remembers who was served last so a conflict goes to the other side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       last_owner_q <= OWN_D;
        else if (take) last_owner_q <= winner;
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester drivers and a memory slave
// produce traffic, a negedge monitor checks grants, bus fields and read data
// against a word-level reference memory and an arbitration rule model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            i_req, i_gnt, i_rvalid;
    logic [AW-1:0]   i_addr;
    logic [DW-1:0]   i_rdata;
    logic            d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata, d_rdata;
    logic [3:0]      d_be;
    logic            m_req, m_we, m_ready, m_rvalid, busy;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata, m_rdata;
    logic [3:0]      m_be;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          gap;
    } cmd_t;

    cmd_t i_cmds[$];
    cmd_t d_cmds[$];
    bit   i_have, d_have;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference memory (updated from granted stimulus) and slave memory
    // (updated from the bus); both start from the same pattern.
    logic [31:0] ref_mem [16];
    logic [31:0] slv_mem [16];

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5000000 ^ (i * 32'h00010203);
    endfunction

    // Memory slave knobs and state
    int   acc_lo = 0, acc_hi = 0, rsp_lo = 2, rsp_hi = 2;
    bit   stray_en = 0, drop_en = 0;
    bit   s_pending = 0;
    int   s_wait = -1, s_cnt = 0, s_r = 0;
    logic [3:0] s_idx = '0;

    initial begin
        m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        forever begin
            @(posedge clk); #1;
            m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = $urandom;
            if (s_pending) begin
                if (s_cnt == 0) begin
                    m_rvalid = 1'b1; m_rdata = slv_mem[s_idx]; s_pending = 0;
                end else s_cnt--;
            end else if (m_req) begin
                if (s_wait < 0) s_wait = $urandom_range(acc_hi, acc_lo);
                if (s_wait == 0) begin
                    m_ready = 1'b1; s_wait = -1; s_idx = m_addr[5:2];
                    if (m_we) begin
                        for (int b = 0; b < 4; b++)
                            if (m_be[b]) slv_mem[s_idx][8*b +: 8] = m_wdata[8*b +: 8];
                    end else begin
                        s_r = $urandom_range(rsp_hi, rsp_lo);
                        if (s_r == 0) begin
                            m_rvalid = 1'b1; m_rdata = slv_mem[s_idx];
                        end else begin
                            s_pending = 1; s_cnt = s_r - 1;
                        end
                    end
                end else s_wait--;
            end else begin
                s_wait = -1;
                if (stray_en && $urandom_range(7, 0) == 0) m_rvalid = 1'b1;
            end
        end
    end

    // Fetch requester
    initial begin
        cmd_t c;
        int   gap;
        bit   dropped;
        i_req = 1'b0; i_addr = '0; i_have = 0; gap = 0;
        forever begin
            @(posedge clk); #1;
            dropped = 0;
            if (i_req && i_gnt) i_req = 1'b0;
            else if (i_req && drop_en && $urandom_range(15, 0) == 0) begin
                i_req = 1'b0; dropped = 1;
            end
            if (!i_req && !dropped && !rst) begin
                if (!i_have && i_cmds.size() > 0) begin
                    c = i_cmds.pop_front(); i_have = 1; gap = c.gap;
                end
                if (i_have) begin
                    if (gap == 0) begin i_req = 1'b1; i_addr = c.addr; i_have = 0; end
                    else gap--;
                end
            end
        end
    end

    // Load/store requester
    initial begin
        cmd_t c;
        int   gap;
        bit   dropped;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0; d_have = 0; gap = 0;
        forever begin
            @(posedge clk); #1;
            dropped = 0;
            if (d_req && d_gnt) d_req = 1'b0;
            else if (d_req && drop_en && $urandom_range(15, 0) == 0) begin
                d_req = 1'b0; dropped = 1;
            end
            if (!d_req && !dropped && !rst) begin
                if (!d_have && d_cmds.size() > 0) begin
                    c = d_cmds.pop_front(); d_have = 1; gap = c.gap;
                end
                if (d_have) begin
                    if (gap == 0) begin
                        d_req = 1'b1; d_we = c.we; d_addr = c.addr; d_wdata = c.wdata; d_be = c.be;
                        d_have = 0;
                    end else gap--;
                end
            end
        end
    end

    // Monitor / scoreboard state
    logic [31:0] i_exp[$];
    logic [31:0] d_exp[$];
    bit          gq[$];          // grant order, 1 = D
    int          rv_count = 0;
    bit          eg_valid = 0, eg_d = 0, lo_d = 1;
    logic        ex_we, tx_we;
    logic [31:0] ex_addr, ex_wdata, tx_addr, tx_wdata;
    logic [3:0]  ex_be, tx_be;
    bit          tx_open = 0, idle_next = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_outputs",
                    {i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we, busy,
                     |i_rdata, |d_rdata, |m_addr, |m_wdata, |m_be}, 64'd0);
                i_exp.delete(); d_exp.delete();
                eg_valid = 0; tx_open = 0; idle_next = 0; lo_d = 1;
            end else begin
                if (eg_valid || i_gnt || d_gnt) begin
                    chk("grant", {i_gnt, d_gnt}, eg_valid ? (eg_d ? 64'd1 : 64'd2) : 64'd0);
                    if (eg_valid) begin
                        chk("m_req_with_gnt", m_req, 64'd1);
                        gq.push_back(eg_d);
                        lo_d = eg_d;
                        tx_open = 1; tx_we = ex_we; tx_addr = ex_addr; tx_wdata = ex_wdata; tx_be = ex_be;
                        if (ex_we) begin
                            for (int b = 0; b < 4; b++)
                                if (ex_be[b]) ref_mem[ex_addr[5:2]][8*b +: 8] = ex_wdata[8*b +: 8];
                        end else if (eg_d) d_exp.push_back(ref_mem[ex_addr[5:2]]);
                        else               i_exp.push_back(ref_mem[ex_addr[5:2]]);
                    end
                end
                eg_valid = 0;

                if (idle_next) begin
                    chk("idle_after_store", busy, 64'd0);
                    idle_next = 0;
                end
                if (m_req && m_ready) begin
                    chk("m_txn_open", tx_open, 64'd1);
                    chk("m_we", m_we, tx_we);
                    chk("m_addr", m_addr, tx_addr);
                    if (tx_we) begin
                        chk("m_wdata", m_wdata, tx_wdata);
                        chk("m_be", m_be, tx_be);
                        idle_next = 1;
                    end
                    tx_open = 0;
                end

                if (i_rvalid) begin
                    rv_count++;
                    chk("busy_at_i_rvalid", busy, 64'd0);
                    chk("i_rvalid_expected", i_exp.size() > 0, 64'd1);
                    if (i_exp.size() > 0) chk("i_rdata", i_rdata, i_exp.pop_front());
                end
                if (d_rvalid) begin
                    rv_count++;
                    chk("busy_at_d_rvalid", busy, 64'd0);
                    chk("d_rvalid_expected", d_exp.size() > 0, 64'd1);
                    if (d_exp.size() > 0) chk("d_rdata", d_rdata, d_exp.pop_front());
                end

                // Inputs now visible are what the next edge samples.
                if (!busy && (i_req || d_req)) begin
                    eg_valid = 1;
`ifdef ARB_RR_EN
                    eg_d = (i_req && d_req) ? !lo_d : d_req;
`else
                    eg_d = d_req;
`endif
                    if (eg_d) begin
                        ex_we = d_we; ex_addr = d_addr; ex_wdata = d_wdata; ex_be = d_be;
                    end else begin
                        ex_we = 1'b0; ex_addr = i_addr; ex_wdata = '0; ex_be = '0;
                    end
                end
            end
        end
    end

    function automatic cmd_t mk(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be, input int gap);
        cmd_t c;
        c.we = we; c.addr = addr; c.wdata = wdata; c.be = be; c.gap = gap;
        return c;
    endfunction

    task automatic wait_done(input string name, input int budget);
        bit done;
        done = 0;
        for (int n = 0; n < budget && !done; n++) begin
            @(posedge clk); #2;
            done = (i_cmds.size() == 0) && (d_cmds.size() == 0) && !i_have && !d_have &&
                   !i_req && !d_req && !busy && !s_pending &&
                   (i_exp.size() == 0) && (d_exp.size() == 0);
        end
        chk({"done_", name}, done, 64'd1);
    endtask

    initial begin
        int rvc;
        int w;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = init_word(i);
            slv_mem[i] = init_word(i);
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // I-only read: accept first ISSUE cycle, data two cycles later
        acc_lo = 0; acc_hi = 0; rsp_lo = 2; rsp_hi = 2;
        i_cmds.push_back(mk(1'b0, 32'h100, '0, '0, 0));
        wait_done("i_read", 200);

        // Simultaneous load and fetch: D first, I only after D completes
        gq.delete();
        d_cmds.push_back(mk(1'b0, 32'h104, '0, '0, 0));
        i_cmds.push_back(mk(1'b0, 32'h108, '0, '0, 0));
        wait_done("conflict", 200);
        chk("conflict_grant_count", gq.size(), 64'd2);
        chk("conflict_first_is_d", gq[0], 64'd1);
        chk("conflict_second_is_i", gq[1], 64'd0);

        // Partial store, then read the merged word back through fetch
        d_cmds.push_back(mk(1'b1, 32'h200, 32'hDEADBEEF, 4'b0011, 0));
        wait_done("store", 200);
        i_cmds.push_back(mk(1'b0, 32'h200, '0, '0, 0));
        wait_done("store_readback", 200);

        // Combined accept and data in the same ISSUE cycle
        rsp_lo = 0; rsp_hi = 0;
        i_cmds.push_back(mk(1'b0, 32'h10C, '0, '0, 0));
        d_cmds.push_back(mk(1'b0, 32'h110, '0, '0, 2));
        wait_done("combined", 200);

        // Reset while waiting in RESP; the late m_rvalid must be ignored
        rsp_lo = 6; rsp_hi = 6;
        i_cmds.push_back(mk(1'b0, 32'h104, '0, '0, 0));
        w = 0;
        while (!s_pending && w < 50) begin @(posedge clk); #2; w++; end
        chk("reached_resp", s_pending, 64'd1);
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        rvc = rv_count;
        repeat (12) @(posedge clk);
        #2;
        chk("no_rvalid_after_reset", rv_count, rvc);
        chk("idle_after_reset", busy, 64'd0);

        // Both requesters held for four transactions each
        rsp_lo = 1; rsp_hi = 1;
        gq.delete();
        for (int k = 0; k < 4; k++) begin
            d_cmds.push_back(mk(1'b0, 32'h100 + 32'(4 * k), '0, '0, 0));
            i_cmds.push_back(mk(1'b0, 32'h120 + 32'(4 * k), '0, '0, 0));
        end
        wait_done("held_both", 400);
        chk("held_grant_count", gq.size(), 64'd8);
`ifdef ARB_RR_EN
        for (int k = 1; k < 4; k++) chk("rr_alternates", gq[k] != gq[k-1], 64'd1);
`else
        for (int k = 0; k < 4; k++) chk("fixed_d_first", gq[k], 64'd1);
`endif

        // Random traffic with variable latency, strays and dropped requests
        acc_lo = 0; acc_hi = 2; rsp_lo = 0; rsp_hi = 3;
        stray_en = 1; drop_en = 1;
        for (int k = 0; k < 120; k++) begin
            i_cmds.push_back(mk(1'b0, 32'h100 + 32'(4 * $urandom_range(15, 0)), '0, '0,
                                $urandom_range(3, 0)));
            d_cmds.push_back(mk(1'($urandom_range(1, 0)), 32'h100 + 32'(4 * $urandom_range(15, 0)),
                                $urandom, 4'($urandom), $urandom_range(3, 0)));
        end
        wait_done("random", 20000);
        stray_en = 0; drop_en = 0;
        repeat (5) @(posedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
